// File: rtl/p2s_frame_scheduler.sv
// Round-robin arbiter feeding one shared parallel-to-serial lane.
// Each granted word is shifted out MSB-first with start/last qualifiers and its source index.
module p2s_frame_scheduler #(
  parameter  int NUM_REQ = 4,
  parameter  int WIDTH   = 4,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_en,
  input  logic [NUM_REQ-1:0]       i_req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]       o_req_ready,
  output logic                     o_dout,
  output logic                     o_frame_valid,
  output logic                     o_frame_start,
  output logic                     o_frame_last,
  output logic [IDW-1:0]           o_src_id,
  output logic                     o_busy
);
  localparam int             CW      = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_MAX = CW'(WIDTH - 1);
  localparam logic [IDW-1:0] LG_RST  = IDW'(NUM_REQ - 1);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shreg;
  logic [IDW-1:0]   r_last_grant;
  logic             r_dout;
  logic             r_fv;
  logic             r_fs;
  logic             r_fl;
  logic [IDW-1:0]   r_src;

  logic             w_found;
  logic [IDW-1:0]   w_winner;
  logic             w_window;
  logic             w_grant;
  logic [WIDTH-1:0] w_word;

  // Rotating priority: the requester right after last_grant has distance 0.
  always_comb begin
    int v_best;
    int v_dist;
    v_best   = NUM_REQ;
    v_dist   = 0;
    w_winner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      v_dist = (i - int'(r_last_grant) - 1 + 2 * NUM_REQ) % NUM_REQ;
      if (i_req_valid[i] && (v_dist < v_best)) begin
        v_best   = v_dist;
        w_winner = IDW'(i);
      end
    end
    w_found = (v_best < NUM_REQ);
  end

  assign w_window = (r_state == S_IDLE) || (r_cnt == CNT_MAX);
  assign w_grant  = i_rst_n && i_en && w_window && w_found;

  always_comb begin
    o_req_ready = '0;
    w_word      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDW'(i) == w_winner) begin
        w_word = i_req_data[i*WIDTH +: WIDTH];
        o_req_ready[i] = w_grant;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_last_grant <= LG_RST;
      r_dout       <= 1'b0;
      r_fv         <= 1'b0;
      r_fs         <= 1'b0;
      r_fl         <= 1'b0;
      r_src        <= '0;
    end else if (w_grant) begin
      r_state      <= S_SHIFT;
      r_cnt        <= '0;
      r_last_grant <= w_winner;
      r_src        <= w_winner;
      r_dout       <= w_word[WIDTH-1];
      r_fv         <= 1'b1;
      r_fs         <= 1'b1;
      r_fl         <= 1'b0;
    end else if (r_state == S_SHIFT) begin
      if (r_cnt == CNT_MAX) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_dout  <= 1'b0;
        r_fv    <= 1'b0;
        r_fs    <= 1'b0;
        r_fl    <= 1'b0;
      end else begin
        r_cnt  <= r_cnt + 1'b1;
        r_dout <= r_shreg[WIDTH-1];
        r_fs   <= 1'b0;
        r_fl   <= (r_cnt == CNT_MAX - 1'b1);
      end
    end
  end

  // Holds the bits still to be sent; its MSB is the next bit for dout.
  always_ff @(posedge i_clk) begin
    if (w_grant) begin
      r_shreg <= w_word << 1;
    end else if (r_state == S_SHIFT) begin
      r_shreg <= r_shreg << 1;
    end
  end

  assign o_dout        = r_dout;
  assign o_frame_valid = r_fv;
  assign o_frame_start = r_fs;
  assign o_frame_last  = r_fl;
  assign o_src_id      = r_src;
  assign o_busy        = r_fv;
endmodule

// File: tb/tb_p2s_frame_scheduler.sv
// Bench for p2s_frame_scheduler: frame-position reference model plus directed and random scenarios.
module tb_p2s_frame_scheduler;
  localparam int NR = 4;
  localparam int W  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic [NR-1:0] valid = '0;
  logic [NR*W-1:0] data = '0;
  logic [NR-1:0] ready;
  logic dout, fv, fs, fl, busy;
  logic [1:0] src;

  logic en2 = 1'b0;
  logic [1:0] valid2 = '0;
  logic [15:0] data2 = '0;
  logic [1:0] ready2;
  logic dout2, fv2, fs2, fl2, busy2;
  logic src2;

  int checks = 0;
  int errors = 0;

  int m_pos;
  int m_src;
  int m_lg;
  logic [W-1:0] m_word;
  logic [NR-1:0] m_acc;

  always #5 clk = ~clk;

  p2s_frame_scheduler #(.NUM_REQ(4), .WIDTH(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_req_valid(valid), .i_req_data(data),
    .o_req_ready(ready), .o_dout(dout), .o_frame_valid(fv), .o_frame_start(fs),
    .o_frame_last(fl), .o_src_id(src), .o_busy(busy)
  );

  p2s_frame_scheduler #(.NUM_REQ(2), .WIDTH(8)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en2), .i_req_valid(valid2), .i_req_data(data2),
    .o_req_ready(ready2), .o_dout(dout2), .o_frame_valid(fv2), .o_frame_start(fs2),
    .o_frame_last(fl2), .o_src_id(src2), .o_busy(busy2)
  );

  // A frame occupies positions 0..W-1; a new grant is possible when idle or at the last position.
  function automatic logic [NR-1:0] exp_ready();
    logic [NR-1:0] r;
    r = '0;
    if (rst_n && en && (m_pos < 0 || m_pos == W-1)) begin
      for (int k = 1; k <= NR; k++) begin
        if (valid[(m_lg + k) % NR]) begin
          r[(m_lg + k) % NR] = 1'b1;
          break;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] exp_outs();
    if (m_pos < 0) return {4'b0000, 2'(m_src), 1'b0};
    return {m_word[W-1-m_pos], 1'b1, (m_pos == 0), (m_pos == W-1), 2'(m_src), 1'b1};
  endfunction

  task automatic model_edge();
    m_acc = exp_ready();
    if (m_acc != '0) begin
      for (int i = 0; i < NR; i++) begin
        if (m_acc[i]) begin
          m_src  = i;
          m_lg   = i;
          m_word = data[i*W +: W];
        end
      end
      m_pos = 0;
    end else if (m_pos == W-1) begin
      m_pos = -1;
    end else if (m_pos >= 0) begin
      m_pos++;
    end
  endtask

  task automatic model_reset();
    m_pos = -1;
    m_lg  = NR - 1;
    m_src = 0;
    m_acc = '0;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    valid = '0;
    en = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b1;
    valid = '1;
    data = 16'h1234;
    en2 = 1'b1;
    valid2 = 2'b11;
    model_reset();
    @(negedge clk);
    checks++;
    if (ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", ready); end
    checks++;
    if ({dout, fv, fs, fl, src, busy} !== 7'b0) begin
      errors++; $display("FAIL reset_outs: got %b expected 0000000", {dout, fv, fs, fl, src, busy});
    end
    checks++;
    if (ready2 !== 2'b00 || fv2 !== 1'b0) begin
      errors++; $display("FAIL reset_dut2: got ready %b fv %b expected 00 0", ready2, fv2);
    end
    en2 = 1'b0;
    valid2 = '0;
    valid = '0;
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [3:0] pat;
    pat = 4'hA;
    @(negedge clk);
    en = 1'b1;
    valid = 4'b0001;
    data = 16'h000A;
    #1;
    checks++;
    if (ready !== 4'b0001 || ready !== exp_ready()) begin
      errors++; $display("FAIL single_ready: got %b expected 0001", ready);
    end
    tick();
    valid = '0;
    for (int i = 0; i < W + 2; i++) begin
      checks++;
      if ({dout, fv, fs, fl, src, busy} !== exp_outs()) begin
        errors++; $display("FAIL single_outs[%0d]: got %b expected %b", i, {dout, fv, fs, fl, src, busy}, exp_outs());
      end
      if (i < W) begin
        checks++;
        if (dout !== pat[W-1-i] || src !== 2'd0) begin
          errors++; $display("FAIL single_bit[%0d]: got %b/%0d expected %b/0", i, dout, src, pat[W-1-i]);
        end
      end
      @(negedge clk);
      #1;
      checks++;
      if (ready !== exp_ready()) begin errors++; $display("FAIL single_idle_ready: got %b expected %b", ready, exp_ready()); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int grants[$];
    int exp_g[5];
    bit started;
    exp_g = '{0, 1, 2, 3, 0};
    started = 1'b0;
    apply_reset();
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      en = 1'b1;
      valid = 4'b1111;
      data = 16'h8421;
      #1;
      checks++;
      if (ready !== exp_ready()) begin errors++; $display("FAIL b2b_ready[%0d]: got %b expected %b", c, ready, exp_ready()); end
      for (int i = 0; i < NR; i++) if (ready[i]) grants.push_back(i);
      tick();
      started = 1'b1;
      checks++;
      if ({dout, fv, fs, fl, src, busy} !== exp_outs()) begin
        errors++; $display("FAIL b2b_outs[%0d]: got %b expected %b", c, {dout, fv, fs, fl, src, busy}, exp_outs());
      end
      if (started) begin
        checks++;
        if (fv !== 1'b1) begin errors++; $display("FAIL b2b_gap[%0d]: got frame_valid %b expected 1", c, fv); end
      end
    end
    checks++;
    if (grants.size() < 5) begin
      errors++; $display("FAIL b2b_grant_count: got %0d expected at least 5", grants.size());
    end else begin
      for (int j = 0; j < 5; j++) begin
        checks++;
        if (grants[j] != exp_g[j]) begin errors++; $display("FAIL b2b_order[%0d]: got %0d expected %0d", j, grants[j], exp_g[j]); end
      end
    end
  endtask

  task automatic test_pair();
    apply_reset();
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      en = 1'b1;
      valid = 4'b1010;
      data = 16'($urandom);
      #1;
      checks++;
      if (ready !== exp_ready() || ready[0] !== 1'b0 || ready[2] !== 1'b0) begin
        errors++; $display("FAIL pair_ready[%0d]: got %b expected %b", c, ready, exp_ready());
      end
      tick();
      checks++;
      if ({dout, fv, fs, fl, src, busy} !== exp_outs()) begin
        errors++; $display("FAIL pair_outs[%0d]: got %b expected %b", c, {dout, fv, fs, fl, src, busy}, exp_outs());
      end
    end
  endtask

  task automatic test_en_drop();
    apply_reset();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      valid = 4'b0001;
      data = 16'h000C;
      if (c == 0) en = 1'b1;
      if (c == 2) en = 1'b0;
      if (c == 8) en = 1'b1;
      #1;
      checks++;
      if (ready !== exp_ready()) begin errors++; $display("FAIL en_ready[%0d]: got %b expected %b", c, ready, exp_ready()); end
      tick();
      checks++;
      if ({dout, fv, fs, fl, src, busy} !== exp_outs()) begin
        errors++; $display("FAIL en_outs[%0d]: got %b expected %b", c, {dout, fv, fs, fl, src, busy}, exp_outs());
      end
    end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      en = 1'b1;
      valid = 4'b0110;
      data = 16'h0F50;
      #1;
      tick();
    end
    checks++;
    if ({dout, fv, fs, fl, src, busy} !== exp_outs()) begin
      errors++; $display("FAIL mrst_pre: got %b expected %b", {dout, fv, fs, fl, src, busy}, exp_outs());
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({dout, fv, fs, fl, src, busy} !== 7'b0 || ready !== 4'b0000) begin
      errors++; $display("FAIL mrst_async: got %b ready %b expected 0000000 0000", {dout, fv, fs, fl, src, busy}, ready);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      rst_n = 1'b1;
      valid = 4'b0011;
      data = 16'h00A3;
      #1;
      if (c == 0) begin
        checks++;
        if (ready !== 4'b0001) begin errors++; $display("FAIL mrst_first_grant: got %b expected 0001", ready); end
      end
      checks++;
      if (ready !== exp_ready()) begin errors++; $display("FAIL mrst_ready[%0d]: got %b expected %b", c, ready, exp_ready()); end
      tick();
      checks++;
      if ({dout, fv, fs, fl, src, busy} !== exp_outs()) begin
        errors++; $display("FAIL mrst_outs[%0d]: got %b expected %b", c, {dout, fv, fs, fl, src, busy}, exp_outs());
      end
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      en = ($urandom % 5) != 0;
      for (int i = 0; i < NR; i++) begin
        if (!valid[i] && ($urandom % 3) == 0) begin
          valid[i] = 1'b1;
          data[i*W +: W] = W'($urandom);
        end
      end
      #1;
      checks++;
      if (ready !== exp_ready()) begin errors++; $display("FAIL rand_ready[%0d]: got %b expected %b", c, ready, exp_ready()); end
      tick();
      valid = valid & ~m_acc;
      checks++;
      if ({dout, fv, fs, fl, src, busy} !== exp_outs()) begin
        errors++; $display("FAIL rand_outs[%0d]: got %b expected %b", c, {dout, fv, fs, fl, src, busy}, exp_outs());
      end
    end
  endtask

  task automatic test_wide();
    logic [7:0] pat;
    int fv_cycles;
    pat = 8'hA5;
    fv_cycles = 0;
    apply_reset();
    @(negedge clk);
    en2 = 1'b1;
    valid2 = 2'b10;
    data2 = 16'hA500;
    #1;
    checks++;
    if (ready2 !== 2'b10) begin errors++; $display("FAIL wide_ready: got %b expected 10", ready2); end
    @(posedge clk);
    #1;
    valid2 = '0;
    for (int i = 0; i < 10; i++) begin
      if (fv2 === 1'b1) fv_cycles++;
      if (i < 8) begin
        checks++;
        if ({dout2, fv2, fs2, fl2, src2, busy2} !== {pat[7-i], 1'b1, (i == 0), (i == 7), 1'b1, 1'b1}) begin
          errors++; $display("FAIL wide_bit[%0d]: got %b expected %b", i, {dout2, fv2, fs2, fl2, src2, busy2},
                             {pat[7-i], 1'b1, (i == 0), (i == 7), 1'b1, 1'b1});
        end
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (fv_cycles != 8) begin errors++; $display("FAIL wide_fv_len: got %0d expected 8", fv_cycles); end
    en2 = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_back_to_back();
    test_pair();
    test_en_drop();
    test_mid_reset();
    test_random();
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
